branch_ctrl: RTL and testbench

BRANCH_CTRL -- requirements
Module: branch_ctrl

---
 rtl/branch_ctrl_pkg.sv | 23 ++
 rtl/branch_comp.sv | 24 ++
 rtl/branch_ctrl.sv | 132 +++++++++++++
 tb/tb_branch_ctrl.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/branch_ctrl_pkg.sv
// Shared encodings, FSM state type and default widths for the branch controller.
package branch_ctrl_pkg;

  localparam int DEF_REG_DATA_WIDTH       = 16;
  localparam int DEF_BRANCH_CONTROL_WIDTH = 2;
  localparam int DEF_PC_WIDTH             = 16;
  localparam int DEF_FLUSH_CYCLES         = 2;
  localparam int FLUSH_CNT_WIDTH          = 3;
  localparam int TAKEN_COUNT_WIDTH        = 16;

  localparam logic [1:0] BRANCH_NONE = 2'b00;
  localparam logic [1:0] BRANCH_EQ   = 2'b01;
  localparam logic [1:0] BRANCH_GT   = 2'b10;
  localparam logic [1:0] BRANCH_LT   = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_EVAL     = 2'd1,
    ST_REDIRECT = 2'd2,
    ST_FLUSH    = 2'd3
  } state_e;

endpackage

// File: rtl/branch_comp.sv
// Unsigned branch-condition evaluator; purely combinational.
module branch_comp
  import branch_ctrl_pkg::*;
#(
  parameter int REG_DATA_WIDTH       = DEF_REG_DATA_WIDTH,
  parameter int BRANCH_CONTROL_WIDTH = DEF_BRANCH_CONTROL_WIDTH
) (
  input  logic [REG_DATA_WIDTH-1:0]       data_1_i,
  input  logic [REG_DATA_WIDTH-1:0]       data_2_i,
  input  logic [BRANCH_CONTROL_WIDTH-1:0] ctrl_i,
  output logic                            taken_o
);

  always_comb begin
    taken_o = 1'b0;
    case (ctrl_i)
      BRANCH_CONTROL_WIDTH'(BRANCH_EQ): taken_o = (data_1_i == data_2_i);
      BRANCH_CONTROL_WIDTH'(BRANCH_GT): taken_o = (data_1_i >  data_2_i);
      BRANCH_CONTROL_WIDTH'(BRANCH_LT): taken_o = (data_1_i <  data_2_i);
      default:                          taken_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/branch_ctrl.sv
// Branch resolution FSM: capture, evaluate, redirect fetch, then flush for FLUSH_CYCLES.
// Optional feature macro: BRANCH_STATS_EN adds a saturating taken_count output.
module branch_ctrl
  import branch_ctrl_pkg::*;
#(
  parameter int REG_DATA_WIDTH       = DEF_REG_DATA_WIDTH,
  parameter int BRANCH_CONTROL_WIDTH = DEF_BRANCH_CONTROL_WIDTH,
  parameter int PC_WIDTH             = DEF_PC_WIDTH,
  parameter int FLUSH_CYCLES         = DEF_FLUSH_CYCLES
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            req_valid,
  output logic                            req_ready,
  input  logic [REG_DATA_WIDTH-1:0]       data_1,
  input  logic [REG_DATA_WIDTH-1:0]       data_2,
  input  logic [BRANCH_CONTROL_WIDTH-1:0] branch_control,
  input  logic [PC_WIDTH-1:0]             pc,
  input  logic [PC_WIDTH-1:0]             offset,
  output logic                            redirect_valid,
  output logic [PC_WIDTH-1:0]             redirect_pc,
  output logic                            flush,
  output logic                            busy
`ifdef BRANCH_STATS_EN
  ,
  output logic [TAKEN_COUNT_WIDTH-1:0]    taken_count
`endif
);

  state_e                          state_q, state_d;
  logic [REG_DATA_WIDTH-1:0]       data_1_q, data_2_q;
  logic [BRANCH_CONTROL_WIDTH-1:0] ctrl_q;
  logic [PC_WIDTH-1:0]             pc_q, offset_q;
  logic [PC_WIDTH-1:0]             redirect_pc_q, redirect_pc_d;
  logic [FLUSH_CNT_WIDTH-1:0]      flush_cnt_q, flush_cnt_d;
  logic                            capture;
  logic                            taken;
  logic [PC_WIDTH-1:0]             target;

  branch_comp #(
    .REG_DATA_WIDTH       (REG_DATA_WIDTH),
    .BRANCH_CONTROL_WIDTH (BRANCH_CONTROL_WIDTH)
  ) u_comp (
    .data_1_i (data_1_q),
    .data_2_i (data_2_q),
    .ctrl_i   (ctrl_q),
    .taken_o  (taken)
  );

  // Target wraps naturally at PC_WIDTH bits.
  assign target = pc_q + PC_WIDTH'(1) + offset_q;

  always_comb begin
    state_d       = state_q;
    flush_cnt_d   = flush_cnt_q;
    redirect_pc_d = redirect_pc_q;
    capture       = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          capture = 1'b1;
          state_d = ST_EVAL;
        end
      end
      ST_EVAL: begin
        if (taken) begin
          state_d       = ST_REDIRECT;
          redirect_pc_d = target;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_REDIRECT: begin
        state_d     = ST_FLUSH;
        flush_cnt_d = FLUSH_CNT_WIDTH'(FLUSH_CYCLES - 1);
      end
      ST_FLUSH: begin
        if (flush_cnt_q == '0) begin
          state_d = ST_IDLE;
        end else begin
          flush_cnt_d = flush_cnt_q - FLUSH_CNT_WIDTH'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      flush_cnt_q   <= '0;
      redirect_pc_q <= '0;
      data_1_q      <= '0;
      data_2_q      <= '0;
      ctrl_q        <= '0;
      pc_q          <= '0;
      offset_q      <= '0;
    end else begin
      state_q       <= state_d;
      flush_cnt_q   <= flush_cnt_d;
      redirect_pc_q <= redirect_pc_d;
      if (capture) begin
        data_1_q <= data_1;
        data_2_q <= data_2;
        ctrl_q   <= branch_control;
        pc_q     <= pc;
        offset_q <= offset;
      end
    end
  end

  assign req_ready      = (state_q == ST_IDLE);
  assign busy           = (state_q != ST_IDLE);
  assign redirect_valid = (state_q == ST_REDIRECT);
  assign flush          = (state_q == ST_FLUSH);
  assign redirect_pc    = redirect_pc_q;

`ifdef BRANCH_STATS_EN
  logic [TAKEN_COUNT_WIDTH-1:0] taken_count_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      taken_count_q <= '0;
    end else if (state_q == ST_REDIRECT && taken_count_q != '1) begin
      taken_count_q <= taken_count_q + TAKEN_COUNT_WIDTH'(1);
    end
  end

  assign taken_count = taken_count_q;
`endif

endmodule

// File: tb/tb_branch_ctrl.sv
// Scoreboard bench for branch_ctrl: driver pushes expectations on accept, monitor pops on completion.
module tb_branch_ctrl;

  localparam int DW = 16;
  localparam int CW = 2;
  localparam int PW = 16;
  localparam int FC = 2;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          req_valid;
  logic          req_ready;
  logic [DW-1:0] data_1, data_2;
  logic [CW-1:0] branch_control;
  logic [PW-1:0] pc, offset;
  logic          redirect_valid;
  logic [PW-1:0] redirect_pc;
  logic          flush;
  logic          busy;
`ifdef BRANCH_STATS_EN
  logic [15:0]   taken_count;
`endif

  always #5 clk = ~clk;

  branch_ctrl #(
    .REG_DATA_WIDTH       (DW),
    .BRANCH_CONTROL_WIDTH (CW),
    .PC_WIDTH             (PW),
    .FLUSH_CYCLES         (FC)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .data_1         (data_1),
    .data_2         (data_2),
    .branch_control (branch_control),
    .pc             (pc),
    .offset         (offset),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .flush          (flush),
    .busy           (busy)
`ifdef BRANCH_STATS_EN
    ,
    .taken_count    (taken_count)
`endif
  );

  typedef struct {
    bit          taken;
    logic [15:0] target;
    int          acc;
    logic [1:0]  ctrl;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   n_checks = 0;
  int   n_errors = 0;
  int   taken_total = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic bit exp_taken(input logic [15:0] a, input logic [15:0] b, input logic [1:0] c);
    case (c)
      2'b01:   return (a == b);
      2'b10:   return (a > b);
      2'b11:   return (a < b);
      default: return 1'b0;
    endcase
  endfunction

  // Monitor: accumulates what the DUT does during one transaction.
  bit          in_txn = 0;
  int          rv_n, rv_cyc, fl_n, fl_first, fl_last;
  logic [15:0] rv_pc;
  logic [15:0] hold_pc = 16'h0;

  task automatic finish_txn();
    exp_t e;
    if (sb.size() == 0) begin
      check_eq("sb_empty", 32'd1, 32'd0);
      return;
    end
    e = sb.pop_front();
    check_eq("taken", rv_n, {31'd0, e.taken});
    if (e.taken) begin
      check_eq("redirect_pc", {16'd0, rv_pc}, {16'd0, e.target});
      check_eq("redirect_lat", rv_cyc - e.acc, 2);
      check_eq("flush_len", fl_n, FC);
      check_eq("flush_start", fl_first - e.acc, 3);
      check_eq("flush_contig", fl_last - fl_first + 1, FC);
      check_eq("ready_lat_taken", cyc - e.acc, 3 + FC);
    end else begin
      check_eq("flush_len_nt", fl_n, 0);
      check_eq("ready_lat_nt", cyc - e.acc, 2);
    end
    $display("txn acc=%0d ctrl=%0d taken=%0b target=0x%04h done=%0d", e.acc, e.ctrl, e.taken, e.target, cyc);
  endtask

  always @(negedge clk) begin
    if (!rst_n) begin
      in_txn  = 0;
      hold_pc = 16'h0;
      sb.delete();
    end else begin
      if (busy === 1'b1 && !in_txn) begin
        in_txn = 1;
        rv_n   = 0;
        fl_n   = 0;
      end
      if (in_txn) begin
        if (redirect_valid) begin
          rv_n++;
          rv_cyc = cyc;
          rv_pc  = redirect_pc;
          if (sb.size() > 0) hold_pc = sb[0].target;
        end else begin
          check_eq("pc_hold", {16'd0, redirect_pc}, {16'd0, hold_pc});
        end
        if (flush) begin
          if (fl_n == 0) fl_first = cyc;
          fl_last = cyc;
          fl_n++;
        end
        if (req_ready) begin
          in_txn = 0;
          finish_txn();
        end
      end
    end
  end

  task automatic send(input logic [15:0] d1, input logic [15:0] d2, input logic [1:0] c,
                      input logic [15:0] p, input logic [15:0] o, input bit hold);
    exp_t e;
    bit   done = 0;
    @(negedge clk);
    data_1 = d1; data_2 = d2; branch_control = c; pc = p; offset = o;
    req_valid = 1'b1;
    for (int i = 0; i < 60 && !done; i++) begin
      if (i > 0) @(negedge clk);
      if (req_ready) done = 1;
    end
    if (!done) begin
      check_eq("accept_timeout", 32'd0, 32'd1);
      req_valid = 1'b0;
      return;
    end
    e.taken  = exp_taken(d1, d2, c);
    e.target = p + 16'd1 + o;
    e.acc    = cyc;
    e.ctrl   = c;
    sb.push_back(e);
    if (e.taken) taken_total++;
    @(posedge clk);
    #1;
    data_1 = 16'($urandom); data_2 = 16'($urandom); branch_control = 2'($urandom);
    pc = 16'($urandom); offset = 16'($urandom);
    if (!hold) req_valid = 1'b0;
  endtask

  task automatic wait_idle();
    bit done = 0;
    for (int i = 0; i < 100 && !done; i++) begin
      @(negedge clk);
      if (sb.size() == 0 && req_ready && !in_txn) done = 1;
    end
    if (!done) check_eq("idle_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    bit found;
    rst_n = 1'b0; req_valid = 1'b0;
    data_1 = '0; data_2 = '0; branch_control = '0; pc = '0; offset = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_eq("rst_req_ready", req_ready, 1);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_flush", flush, 0);
    check_eq("rst_redirect_valid", redirect_valid, 0);
    check_eq("rst_redirect_pc", redirect_pc, 0);
`ifdef BRANCH_STATS_EN
    check_eq("rst_taken_count", taken_count, 0);
`endif
    #1 rst_n = 1'b1;

    send(16'd3000, 16'd1000, 2'b11, 16'h0020, 16'h0004, 0);
    wait_idle();
    send(16'd3000, 16'd1000, 2'b10, 16'h0010, 16'hFFFC, 0);
    wait_idle();
    send(16'd3000, 16'd3000, 2'b01, 16'h0100, 16'h0002, 0);
    wait_idle();
    send(16'd3000, 16'd3000, 2'b00, 16'h0100, 16'h0002, 0);
    wait_idle();
    send(16'd7, 16'd7, 2'b01, 16'hFFFF, 16'h0000, 0);
    wait_idle();

    // Reset asserted during the first flush cycle.
    send(16'd5, 16'd5, 2'b01, 16'h0200, 16'h0010, 0);
    found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk);
      if (flush) found = 1;
    end
    check_eq("rst_flush_seen", {31'd0, found}, 1);
    #1 rst_n = 1'b0;
    @(negedge clk);
    check_eq("midrst_flush", flush, 0);
    check_eq("midrst_req_ready", req_ready, 1);
    check_eq("midrst_busy", busy, 0);
    check_eq("midrst_redirect_pc", redirect_pc, 0);
`ifdef BRANCH_STATS_EN
    check_eq("midrst_taken_count", taken_count, 0);
`endif
    taken_total = 0;
    #1 rst_n = 1'b1;
    send(16'd1, 16'd9, 2'b11, 16'h0300, 16'h0005, 0);
    wait_idle();

    // Back-to-back with req_valid held and inputs changing while busy.
    for (int k = 0; k < 16; k++) begin
      send(16'($urandom_range(0, 3) * 1000), 16'($urandom_range(0, 3) * 1000),
           2'($urandom), 16'($urandom), 16'($urandom), (k != 15));
    end
    wait_idle();

`ifdef BRANCH_STATS_EN
    check_eq("taken_count", taken_count, taken_total);
`endif
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
